// File: rtl/countdown_timer_if.sv
// Button inputs and display/status outputs of countdown_timer.
// master drives the raw buttons; slave is the timer core.
interface countdown_timer_if;
    logic       set_en;
    logic       sec_up;
    logic       min_up;
    logic       start;
    logic       clear;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       done;
    logic       expire_pulse;

    modport master (
        output set_en, sec_up, min_up, start, clear,
        input  min_tens, min_ones, sec_tens, sec_ones, running, done, expire_pulse
    );

    modport slave (
        input  set_en, sec_up, min_up, start, clear,
        output min_tens, min_ones, sec_tens, sec_ones, running, done, expire_pulse
    );
endinterface

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer with button preset, start/pause and expiry flag.
// Define TMR_DEBOUNCE_EN to add a DB_CYCLES-cycle debouncer after the synchronisers.
module countdown_timer #(
    parameter int unsigned TICK_DIV  = 100_000_000,
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             reset,
    countdown_timer_if.slave tmr
);
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_EXPIRED
    } state_e;

    // Bit order: {set_en, clear, start, min_up, sec_up}
    logic [4:0] sync1_q, sync2_q;
    logic [3:0] lvl, prev_q, rise;
    logic       set_lvl;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= {tmr.set_en, tmr.clear, tmr.start, tmr.min_up, tmr.sec_up};
            sync2_q <= sync1_q;
            prev_q  <= lvl;
        end
    end

`ifdef TMR_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    logic [3:0]    db_q;
    logic [CW-1:0] db_cnt_q [4];

    // Counter runs only while the synchronised level disagrees with the debounced one.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_q <= '0;
            for (int unsigned i = 0; i < 4; i++) db_cnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    db_q[i]     <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign lvl = db_q;
`else
    assign lvl = sync2_q[3:0];
`endif

    assign rise    = lvl & ~prev_q;
    assign set_lvl = sync2_q[4];

    logic sec_rise, min_rise, start_rise, clear_rise;
    assign sec_rise   = rise[0];
    assign min_rise   = rise[1];
    assign start_rise = rise[2];
    assign clear_rise = rise[3];

    state_e        state_q;
    logic [PW-1:0] presc_q;
    logic [3:0]    min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;
    logic          running_q, done_q, expire_q;

    logic [3:0] sec_inc_tens_d, sec_inc_ones_d, min_inc_tens_d, min_inc_ones_d;
    logic [3:0] dec_min_tens_d, dec_min_ones_d, dec_sec_tens_d, dec_sec_ones_d;
    logic       time_nz, time_one;

    always_comb begin
        sec_inc_tens_d = sec_tens_q;
        sec_inc_ones_d = sec_ones_q + 4'd1;
        if (sec_ones_q == 4'd9) begin
            sec_inc_ones_d = 4'd0;
            sec_inc_tens_d = (sec_tens_q == 4'd5) ? 4'd0 : sec_tens_q + 4'd1;
        end
        min_inc_tens_d = min_tens_q;
        min_inc_ones_d = min_ones_q + 4'd1;
        if (min_ones_q == 4'd9) begin
            min_inc_ones_d = 4'd0;
            min_inc_tens_d = (min_tens_q == 4'd5) ? 4'd0 : min_tens_q + 4'd1;
        end

        dec_min_tens_d = min_tens_q;
        dec_min_ones_d = min_ones_q;
        dec_sec_tens_d = sec_tens_q;
        dec_sec_ones_d = sec_ones_q - 4'd1;
        if (sec_ones_q == 4'd0) begin
            dec_sec_ones_d = 4'd9;
            if (sec_tens_q == 4'd0) begin
                dec_sec_tens_d = 4'd5;
                if (min_ones_q == 4'd0) begin
                    dec_min_ones_d = 4'd9;
                    dec_min_tens_d = (min_tens_q == 4'd0) ? 4'd5 : min_tens_q - 4'd1;
                end else begin
                    dec_min_ones_d = min_ones_q - 4'd1;
                end
            end else begin
                dec_sec_tens_d = sec_tens_q - 4'd1;
            end
        end

        time_nz  = |{min_tens_q, min_ones_q, sec_tens_q, sec_ones_q};
        time_one = (min_tens_q == 4'd0) && (min_ones_q == 4'd0) &&
                   (sec_tens_q == 4'd0) && (sec_ones_q == 4'd1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            min_tens_q <= '0;
            min_ones_q <= '0;
            sec_tens_q <= '0;
            sec_ones_q <= '0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            expire_q   <= 1'b0;
        end else begin
            expire_q <= 1'b0;
            if (clear_rise) begin
                state_q    <= ST_IDLE;
                presc_q    <= '0;
                min_tens_q <= '0;
                min_ones_q <= '0;
                sec_tens_q <= '0;
                sec_ones_q <= '0;
                running_q  <= 1'b0;
                done_q     <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_PAUSE: begin
                        if (start_rise && !set_lvl && time_nz) begin
                            // PAUSE keeps its prescaler so the interrupted second resumes
                            if (state_q == ST_IDLE) presc_q <= '0;
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                        end else if (set_lvl) begin
                            if (sec_rise) begin
                                sec_tens_q <= sec_inc_tens_d;
                                sec_ones_q <= sec_inc_ones_d;
                            end
                            if (min_rise) begin
                                min_tens_q <= min_inc_tens_d;
                                min_ones_q <= min_inc_ones_d;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (start_rise) begin
                            state_q   <= ST_PAUSE;
                            running_q <= 1'b0;
                        end else if (presc_q == TICK_LAST) begin
                            presc_q    <= '0;
                            min_tens_q <= dec_min_tens_d;
                            min_ones_q <= dec_min_ones_d;
                            sec_tens_q <= dec_sec_tens_d;
                            sec_ones_q <= dec_sec_ones_d;
                            if (time_one) begin
                                state_q   <= ST_EXPIRED;
                                running_q <= 1'b0;
                                done_q    <= 1'b1;
                                expire_q  <= 1'b1;
                            end
                        end else begin
                            presc_q <= presc_q + 1'b1;
                        end
                    end
                    ST_EXPIRED: begin
                        if (start_rise) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b0;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign tmr.min_tens     = min_tens_q;
    assign tmr.min_ones     = min_ones_q;
    assign tmr.sec_tens     = sec_tens_q;
    assign tmr.sec_ones     = sec_ones_q;
    assign tmr.running      = running_q;
    assign tmr.done         = done_q;
    assign tmr.expire_pulse = expire_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboarded bench for countdown_timer: a cycle-level reference model queues every
// expected output change with its cycle number; a monitor pops on each DUT change.
module tb_countdown_timer;
    localparam int unsigned TICK_DIV  = 4;
    localparam int unsigned DB_CYCLES = 3;
`ifdef TMR_DEBOUNCE_EN
    localparam int PH = DB_CYCLES + 2;
    localparam int PG = DB_CYCLES + 2;
`else
    localparam int PH = 1;
    localparam int PG = 3;
`endif
    localparam logic [3:0] B_SEC = 4'b0001;
    localparam logic [3:0] B_MIN = 4'b0010;
    localparam logic [3:0] B_STA = 4'b0100;
    localparam logic [3:0] B_CLR = 4'b1000;

    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_EXP = 3;

    logic clk = 1'b0;
    logic reset;
    logic set_en_r;
    logic [3:0] btn_r;

    always #5 clk = ~clk;

    countdown_timer_if ifc ();
    assign ifc.set_en = set_en_r;
    assign ifc.sec_up = btn_r[0];
    assign ifc.min_up = btn_r[1];
    assign ifc.start  = btn_r[2];
    assign ifc.clear  = btn_r[3];

    countdown_timer #(.TICK_DIV(TICK_DIV), .DB_CYCLES(DB_CYCLES)) dut (
        .clk   (clk),
        .reset (reset),
        .tmr   (ifc)
    );

    typedef struct {
        int cyc;
        int mm;
        int ss;
        bit run;
        bit dn;
        bit xp;
    } snap_t;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    bit    mon_en = 1'b0;
    snap_t exp_q[$];

    int m_mm, m_ss, m_cnt, m_st;
    bit m_pulse;
    bit [4:0] s_hist[$];
    bit [3:0] l_hist[$];
    snap_t m_last;

    function automatic bit same_val(snap_t a, snap_t b);
        return a.mm == b.mm && a.ss == b.ss && a.run == b.run && a.dn == b.dn && a.xp == b.xp;
    endfunction

    // Reference model: a button acts at edge k when its level after edge k-1 is high and
    // after edge k-2 was low; the level follows the raw input two samples late, or only
    // after DB_CYCLES agreeing samples when debouncing.
    initial begin : model
        bit [3:0] act;
        bit [3:0] lk;
        bit       set_l;
        bit       all;
        int       t;
        snap_t    cur;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (reset) begin
                m_mm = 0; m_ss = 0; m_cnt = 0; m_st = S_IDLE; m_pulse = 1'b0;
                s_hist.delete();
                l_hist.delete();
                for (int i = 0; i < 12; i++) begin
                    s_hist.push_back('0);
                    l_hist.push_back('0);
                end
                exp_q.delete();
                m_last = '{cyc: 0, mm: 0, ss: 0, run: 0, dn: 0, xp: 0};
            end else begin
                act   = l_hist[$] & ~l_hist[$-1];
                set_l = s_hist[$-1][4];
                m_pulse = 1'b0;
                if (act[3]) begin
                    m_mm = 0; m_ss = 0; m_cnt = 0; m_st = S_IDLE;
                end else begin
                    case (m_st)
                        S_IDLE, S_PAUSE: begin
                            if (act[2] && !set_l && (m_mm != 0 || m_ss != 0)) begin
                                if (m_st == S_IDLE) m_cnt = 0;
                                m_st = S_RUN;
                            end else if (set_l) begin
                                if (act[0]) m_ss = (m_ss + 1) % 60;
                                if (act[1]) m_mm = (m_mm + 1) % 60;
                            end
                        end
                        S_RUN: begin
                            if (act[2]) m_st = S_PAUSE;
                            else if (m_cnt == int'(TICK_DIV) - 1) begin
                                m_cnt = 0;
                                t = m_mm * 60 + m_ss - 1;
                                m_mm = t / 60;
                                m_ss = t % 60;
                                if (t == 0) begin
                                    m_st = S_EXP;
                                    m_pulse = 1'b1;
                                end
                            end else m_cnt = m_cnt + 1;
                        end
                        default: if (act[2]) m_st = S_IDLE;
                    endcase
                end
`ifdef TMR_DEBOUNCE_EN
                lk = l_hist[$];
                for (int b = 0; b < 4; b++) begin
                    all = 1'b1;
                    for (int j = 1; j <= int'(DB_CYCLES); j++)
                        if (s_hist[$-j][b] == l_hist[$][b]) all = 1'b0;
                    if (all) lk[b] = ~lk[b];
                end
`else
                lk = s_hist[$][3:0];
`endif
                l_hist.push_back(lk);
                void'(l_hist.pop_front());
            end
            s_hist.push_back({set_en_r, btn_r});
            void'(s_hist.pop_front());
            cur = '{cyc: cyc, mm: m_mm, ss: m_ss, run: (m_st == S_RUN), dn: (m_st == S_EXP), xp: m_pulse};
            if (!reset && !same_val(cur, m_last)) begin
                exp_q.push_back(cur);
                m_last = cur;
            end
        end
    end

    initial begin : monitor
        snap_t d, d_last, e;
        int mt, mo, st, so;
        d_last = '{cyc: 0, mm: 0, ss: 0, run: 0, dn: 0, xp: 0};
        forever begin
            @(negedge clk);
            if (mon_en) begin
                mt = ifc.min_tens; mo = ifc.min_ones; st = ifc.sec_tens; so = ifc.sec_ones;
                d = '{cyc: cyc, mm: mt * 10 + mo, ss: st * 10 + so,
                      run: ifc.running, dn: ifc.done, xp: ifc.expire_pulse};
                if (!same_val(d, d_last)) begin
                    checks++;
                    if (mt > 5 || mo > 9 || st > 5 || so > 9) begin
                        errors++;
                        $display("FAIL bcd_range: got %0d%0d:%0d%0d required tens<=5 ones<=9", mt, mo, st, so);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL scoreboard_extra: got cyc=%0d %0d:%0d run=%0d done=%0d xp=%0d required no change",
                                 d.cyc, d.mm, d.ss, d.run, d.dn, d.xp);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.cyc != d.cyc || !same_val(e, d)) begin
                            errors++;
                            $display("FAIL scoreboard: got cyc=%0d %0d:%0d run=%0d done=%0d xp=%0d required cyc=%0d %0d:%0d run=%0d done=%0d xp=%0d",
                                     d.cyc, d.mm, d.ss, d.run, d.dn, d.xp, e.cyc, e.mm, e.ss, e.run, e.dn, e.xp);
                        end
                    end
                    d_last = d;
                end
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    e = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_missed: got no change required cyc=%0d %0d:%0d run=%0d done=%0d xp=%0d",
                             e.cyc, e.mm, e.ss, e.run, e.dn, e.xp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, expv);
        end
    endtask

    task automatic chk_time(input string name, input int mm, input int ss);
        chk({name, "_min_tens"}, 32'(ifc.min_tens), 32'(mm / 10));
        chk({name, "_min_ones"}, 32'(ifc.min_ones), 32'(mm % 10));
        chk({name, "_sec_tens"}, 32'(ifc.sec_tens), 32'(ss / 10));
        chk({name, "_sec_ones"}, 32'(ifc.sec_ones), 32'(ss % 10));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] m, input int hold, input int gap);
        btn_r = m;
        idle(hold);
        btn_r = '0;
        idle(gap);
    endtask

    task automatic presses(input logic [3:0] m, input int n);
        repeat (n) press(m, PH, PG);
    endtask

    task automatic wait_model(input string name, input int st, input int cnt, input int mm, input int ss);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (m_st == st && (cnt < 0 || m_cnt == cnt) && (mm < 0 || (m_mm == mm && m_ss == ss)))
                found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s: got timeout required condition within 60 cycles", name);
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no completion required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int r, hold, gap;
        reset = 1'b1;
        set_en_r = 1'b0;
        btn_r = '0;
        idle(3);
        reset = 1'b0;
        chk_time("reset", 0, 0);
        chk("reset_running", 32'(ifc.running), 0);
        chk("reset_done", 32'(ifc.done), 0);
        chk("reset_expire", 32'(ifc.expire_pulse), 0);
        mon_en = 1'b1;

        // Preset and seconds wrap
        set_en_r = 1'b1;
        idle(3);
        presses(B_MIN, 2);
        presses(B_SEC, 5);
        chk_time("preset", 2, 5);
        chk("preset_running", 32'(ifc.running), 0);
        presses(B_SEC, 60);
        chk_time("sec_wrap", 2, 5);

        // Run 00:02 to expiry
        press(B_CLR, PH, PG);
        presses(B_SEC, 2);
        set_en_r = 1'b0;
        idle(3);
        press(B_STA, PH, PG);
        idle(20);
        chk_time("expired", 0, 0);
        chk("expired_done", 32'(ifc.done), 1);
        chk("expired_running", 32'(ifc.running), 0);

        // Acknowledge, then 01:00 -> 00:59 borrow
        press(B_STA, PH, PG);
        set_en_r = 1'b1;
        idle(3);
        presses(B_MIN, 1);
        set_en_r = 1'b0;
        idle(3);
        press(B_STA, PH, PG);
        wait_model("wait_0059", S_RUN, -1, 0, 59);
        chk_time("borrow", 0, 59);
        press(B_CLR, PH, PG);

        // Pause mid-prescale and resume
        set_en_r = 1'b1;
        idle(3);
        presses(B_SEC, 10);
        set_en_r = 1'b0;
        idle(3);
        press(B_STA, PH, 0);
        wait_model("wait_cnt0", S_RUN, 0, -1, -1);
        press(B_STA, PH, PG);
        idle(20);
        chk("paused_running", 32'(ifc.running), 0);
        press(B_STA, PH, PG);
        idle(12);
        press(B_CLR, PH, PG);

        // Clear beats start and sec_up at 10:10; start at 00:00 is ignored
        set_en_r = 1'b1;
        idle(3);
        presses(B_MIN, 10);
        presses(B_SEC, 10);
        set_en_r = 1'b0;
        idle(3);
        press(B_STA, PH, PG);
        idle(6);
        press(B_CLR | B_STA | B_SEC, PH, PG);
        chk_time("clear_prio", 0, 0);
        chk("clear_prio_running", 32'(ifc.running), 0);
        press(B_STA, PH, PG);
        idle(6);
        chk("zero_start_running", 32'(ifc.running), 0);

`ifdef TMR_DEBOUNCE_EN
        set_en_r = 1'b1;
        idle(3);
        btn_r = B_MIN;
        idle(2);
        btn_r = '0;
        idle(10);
        chk_time("glitch", 0, 0);
        press(B_MIN, 5, 10);
        chk_time("db_hold", 1, 0);
        set_en_r = 1'b0;
        idle(3);
`endif

        set_en_r = 1'b1;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 19);
            hold = $urandom_range(1, PH + 3);
            gap = $urandom_range(1, PG + 3);
            if (r < 6) press(B_SEC, hold, gap);
            else if (r < 9) press(B_MIN, hold, gap);
            else if (r < 10) press(B_SEC | B_MIN, hold, gap);
            else if (r < 13) press(B_STA, hold, gap);
            else if (r < 14) press(B_CLR, hold, gap);
            else if (r < 16) begin
                set_en_r = ~set_en_r;
                idle($urandom_range(1, 3));
            end else idle($urandom_range(1, 15));
        end
        btn_r = '0;
        idle(30);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Minute:second countdown timer (00:00 to 59:59) with button-driven preset, start/pause and expiry flag.
- Runs on the board clock and drives four BCD digits straight into the display mux's timer input. The seven-segment driver consumes those digits unchanged.
- Raw push-button levels enter directly. Synchronisation and edge detection are internal.

Parameters:
- TICK_DIV, 100_000_000, clk cycles per 1 s countdown tick (must be >= 2).
- DB_CYCLES, 1_000_000, stable-level cycles required by debouncer (only with TMR_DEBOUNCE_EN).

Ports:
- clk  input  1  board clock, all logic on rising edge
- reset  input  1  synchronous active-high reset
- set_en  input  1  level; enables preset adjustment
- sec_up  input  1  button; +1 second per press
- min_up  input  1  button; +1 minute per press
- start  input  1  button; start/pause/acknowledge
- clear  input  1  button; zero digits, go IDLE
- min_tens  output  4  BCD 0-5
- min_ones  output  4  BCD 0-9
- sec_tens  output  4  BCD 0-5
- sec_ones  output  4  BCD 0-9
- running  output  1  high in RUN
- done  output  1  high in EXPIRED
- expire_pulse  output  1  one-cycle pulse on entry to EXPIRED

Behaviour:
- Reset: all digits 0, state IDLE, running=0, done=0, expire_pulse=0, prescaler=0, synchroniser and edge flops cleared.
- Input path:
  - Each button passes through a 2-flop synchroniser, then an edge register.
  - An action fires on the synchronised rising edge.
  - A level first sampled high at edge N takes effect on registered outputs at edge N+2.
  - Holding a button produces exactly one action.
- States:
  - IDLE and PAUSE:
    - If set_en=1: sec_up adds 1 to seconds, 59 wraps to 00 with no carry into minutes. min_up adds 1 to minutes, 59 wraps to 00.
    - start with time != 00:00 goes to RUN. start with 00:00 is ignored. start is ignored while set_en=1.
  - RUN:
    - Prescaler counts 0..TICK_DIV-1. A tick fires on the cycle the count equals TICK_DIV-1.
    - On a tick, time decrements by one second in BCD with borrow. sec_ones 0 borrows from sec_tens. 00 seconds borrows a minute and becomes 59.
    - On a tick at 00:01, time becomes 00:00 and state becomes EXPIRED on the same edge. expire_pulse=1 for that one cycle.
    - start goes to PAUSE and holds the prescaler value. Resuming continues from the held count.
    - sec_up, min_up and set_en are ignored.
  - EXPIRED: digits stay 00:00, done=1. start or clear goes to IDLE.
- Entering RUN from IDLE zeroes the prescaler, so the first decrement lands TICK_DIV cycles after the transition.
- clear: in any state, digits go to 00:00, state IDLE, prescaler 0. This is one cycle, same N+2 latency.
- Priority within a cycle: reset > clear > start > sec_up/min_up > tick.
  - sec_up and min_up together: both apply.
  - A start edge coinciding with a tick in RUN: pause wins and the tick is discarded.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Digit values never leave the BCD range. Verification asserts tens <= 5 and ones <= 9 at all times.

Optional Feature:
- TMR_DEBOUNCE_EN
- Defined:
  - Each synchronised button feeds a per-input counter. The debounced level changes only after DB_CYCLES consecutive cycles at the new level.
  - Action latency becomes N+2+DB_CYCLES.
  - Glitches shorter than DB_CYCLES produce no action.
- Undefined: no debouncer. Edge detection acts directly on the synchroniser output, latency N+2, and every clean synchronised edge is an action.

Test Plan (TICK_DIV=4, DB_CYCLES=3 when enabled):
1. Reset, set_en=1, 2 min_up presses, 5 sec_up presses -> digits 0,2,0,5; running=0. Another 60 sec_up presses -> seconds wrap to 05, minutes stay 02.
2. Preset 00:02, set_en=0, start -> running=1. 00:01 appears 4 cycles after entering RUN, 00:00 at 8 cycles with expire_pulse=1 for 1 cycle, then done=1 and running=0.
3. Preset 01:00, run one tick -> 00:59 (borrow: sec_tens=5, sec_ones=9, min_ones=0).
4. Running, start pressed mid-prescale (count=2) -> PAUSE, digits frozen for 20 cycles. Start again -> next decrement 2 cycles after resume.
5. clear asserted same cycle as start and sec_up while RUN at 10:10 -> 00:00, IDLE, running=0. Separately, start with 00:00 in IDLE -> stays IDLE.
6. With TMR_DEBOUNCE_EN: 2-cycle high glitch on min_up -> no change. 5-cycle hold -> minutes +1, exactly once.
